// File: rtl/fault_vote_countdown.sv
// Debounced arm and K-of-N fault vote driving a thermometer countdown on an LED bar.
// All timing is derived from clk through a sample-rate clock enable.
module fault_vote_countdown #(
   parameter int SAMPLE_DIV = 60000,
   parameter int DEB_N      = 4,
   parameter int N_CH       = 3,
   parameter int VOTE_K     = 2,
   parameter int STEP_DIV   = 50,
   parameter int BLINK_DIV  = 17,
   parameter int LED_W      = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             arm,
   input  logic [N_CH-1:0]  fault_in,
   output logic [LED_W-1:0] leds,
   output logic             fault_vote,
   output logic [1:0]       state,
   output logic             boom
);
   localparam int TW = $clog2(SAMPLE_DIV);
   localparam int DW = $clog2(DEB_N + 1);
   localparam int CW = $clog2(N_CH + 1);
   localparam int LW = $clog2(LED_W + 1);
   localparam int SW = $clog2(STEP_DIV + 1);
   localparam int BW = $clog2(BLINK_DIV + 1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_COUNT = 2'd2, S_DONE = 2'd3} state_t;

   logic [TW-1:0] div_reg;
   logic          tick;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         div_reg <= '0;
      else if (tick)
         div_reg <= '0;
      else
         div_reg <= div_reg + TW'(1);
   end

   assign tick = (div_reg == TW'(SAMPLE_DIV - 1));

   // Bit 0 is the arm switch, bits N_CH:1 are the fault channels.
   logic [N_CH:0] raw;
   logic [N_CH:0] sync1_reg;
   logic [N_CH:0] sync2_reg;
   logic [N_CH:0] db;

   assign raw = {fault_in, arm};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_reg <= '0;
         sync2_reg <= '0;
      end else begin
         sync1_reg <= raw;
         sync2_reg <= sync1_reg;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi <= N_CH; gi++) begin : g_deb
         logic          db_reg;
         logic [DW-1:0] cnt_reg;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               db_reg  <= 1'b0;
               cnt_reg <= '0;
            end else if (tick) begin
               if (sync2_reg[gi] != db_reg) begin
                  if (cnt_reg == DW'(DEB_N - 1)) begin
                     db_reg  <= sync2_reg[gi];
                     cnt_reg <= '0;
                  end else begin
                     cnt_reg <= cnt_reg + DW'(1);
                  end
               end else begin
                  cnt_reg <= '0;
               end
            end
         end

         assign db[gi] = db_reg;
      end
   endgenerate

   logic          arm_db;
   logic [CW-1:0] fault_cnt;
   logic          vote_reg;

   assign arm_db = db[0];

   always_comb begin
      fault_cnt = '0;
      for (int i = 1; i <= N_CH; i++)
         fault_cnt = fault_cnt + CW'(db[i]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         vote_reg <= 1'b0;
      else
         vote_reg <= (fault_cnt >= CW'(VOTE_K));
   end

   function automatic logic [LED_W-1:0] thermo(input logic [LW-1:0] lvl);
      logic [LED_W-1:0] t;
      for (int i = 0; i < LED_W; i++)
         t[i] = (LW'(i) < lvl);
      return t;
   endfunction

   state_t           state_reg;
   logic [LW-1:0]    level_reg;
   logic [SW-1:0]    step_reg;
   logic [BW-1:0]    blink_reg;
   logic             phase_reg;
   logic [LED_W-1:0] leds_reg;
   logic             boom_reg;

   // leds is written alongside the state/level change that drives it, so it never lags a cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
         level_reg <= '0;
         step_reg  <= '0;
         blink_reg <= '0;
         phase_reg <= 1'b1;
         leds_reg  <= '0;
         boom_reg  <= 1'b0;
      end else begin
         boom_reg <= 1'b0;
         if (!arm_db) begin
            state_reg <= S_IDLE;
            level_reg <= '0;
            step_reg  <= '0;
            blink_reg <= '0;
            leds_reg  <= '0;
         end else begin
            case (state_reg)
               S_IDLE: state_reg <= S_ARMED;
               S_ARMED: begin
                  if (vote_reg) begin
                     state_reg <= S_COUNT;
                     step_reg  <= '0;
                  end
               end
               S_COUNT: begin
                  if (!vote_reg) begin
                     state_reg <= S_ARMED;
                     step_reg  <= '0;
                  end else if (tick) begin
                     if (step_reg == SW'(STEP_DIV - 1)) begin
                        step_reg  <= '0;
                        level_reg <= level_reg + LW'(1);
                        if (level_reg == LW'(LED_W - 1)) begin
                           state_reg <= S_DONE;
                           boom_reg  <= 1'b1;
                           blink_reg <= '0;
                           phase_reg <= 1'b1;
                           leds_reg  <= '1;
                        end else begin
                           leds_reg <= thermo(level_reg + LW'(1));
                        end
                     end else begin
                        step_reg <= step_reg + SW'(1);
                     end
                  end
               end
               S_DONE: begin
                  if (tick) begin
                     if (blink_reg == BW'(BLINK_DIV - 1)) begin
                        blink_reg <= '0;
                        phase_reg <= ~phase_reg;
                        leds_reg  <= {LED_W{~phase_reg}};
                     end else begin
                        blink_reg <= blink_reg + BW'(1);
                     end
                  end
               end
               default: state_reg <= S_IDLE;
            endcase
         end
      end
   end

   assign leds       = leds_reg;
   assign fault_vote = vote_reg;
   assign state      = state_reg;
   assign boom       = boom_reg;
endmodule
